// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the pipeline (P) port, the debug/loader (D) port and the data RAM
//   port of the data-memory arbiter into one interface.
//
//   Signal summary (direction as seen by the arbiter):
//     p_req_i, p_addr_i[31:0], p_wdata_i[31:0], p_wmask_i[3:0]   in
//     p_gnt_o, p_stall_o, p_rvalid_o, p_rdata_o[31:0]            out
//     d_req_i, d_addr_i[31:0], d_wdata_i[31:0], d_wmask_i[3:0],
//     d_lock_i                                                   in
//     d_gnt_o, d_rvalid_o, d_rdata_o[31:0]                       out
//     mem_en_o, mem_addr_o[31:0], mem_wdata_o[31:0],
//     mem_wmask_o[3:0]                                           out
//     mem_rdata_i[31:0]                                          in
//
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding environment (requesters and the RAM)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    // pipeline memory stage
    logic        p_req_i;
    logic [31:0] p_addr_i;
    logic [31:0] p_wdata_i;
    logic [3:0]  p_wmask_i;
    logic        p_gnt_o;
    logic        p_stall_o;
    logic        p_rvalid_o;
    logic [31:0] p_rdata_o;
    // debug / loader master
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wmask_i;
    logic        d_lock_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    // data RAM
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  p_req_i, p_addr_i, p_wdata_i, p_wmask_i,
        output p_gnt_o, p_stall_o, p_rvalid_o, p_rdata_o,
        input  d_req_i, d_addr_i, d_wdata_i, d_wmask_i, d_lock_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_en_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_rdata_i
    );

    modport master (
        output p_req_i, p_addr_i, p_wdata_i, p_wmask_i,
        input  p_gnt_o, p_stall_o, p_rvalid_o, p_rdata_o,
        output d_req_i, d_addr_i, d_wdata_i, d_wmask_i, d_lock_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_en_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port data RAM between the pipeline memory stage (P)
//   and the debug/loader master (D). P has fixed priority; D is protected
//   from starvation by a wait counter and may lock the port for multi-beat
//   bursts (bounded by LOCK_MAX). Read data returns to the issuing master
//   one cycle after its request was accepted.
//
//   Ports:
//     clk_i    - clock, all state changes on the rising edge
//     reset_i  - asynchronous, active-high reset
//     bus      - dmem_port_arbiter_if.slave: P port, D port and RAM port
//
//   Parameters:
//     MAX_WAIT - cycles D may wait behind P before it is force-granted
//     LOCK_MAX - max cycles D may hold the port in LOCKED
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    dmem_port_arbiter_if.slave    bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX - 1);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    localparam logic [1:0] ST_ARB     = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          p_rvalid_q, p_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;

    logic          p_gnt;
    logic          d_gnt;

    // Grants: purely combinational from registered state and current requests.
    // Forced low while reset is asserted so nothing reaches the RAM.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset_i) begin
            if (state_q == ST_LOCKED) begin
                // Port reserved for D; idle cycles are not handed to P.
                d_gnt = bus.d_req_i;
            end else begin
                // ARB and EXPIRED arbitrate identically.
                d_gnt = bus.d_req_i & (~bus.p_req_i | (wait_cnt_q == WAIT_MAX));
                p_gnt = bus.p_req_i & ~d_gnt;
            end
        end
    end

    // Next-state, counters and read-valid tracking.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;

        // In LOCKED d_gnt follows d_req, so this also clears wait_cnt there
        // and on the grant that enters LOCKED.
        if (bus.d_req_i && !d_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
        end else begin
            wait_cnt_d = '0;
        end

        case (state_q)
            ST_ARB: begin
                if (d_gnt && bus.d_lock_i) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                lock_cnt_d = lock_cnt_q + LOCK_ONE;
                if (!bus.d_lock_i) begin
                    state_d = ST_ARB;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                // Lock requests are ignored until D drops d_lock_i once, so
                // D cannot immediately re-lock and starve P.
                if (!bus.d_lock_i) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // Only reads return data; a write grant produces no rvalid.
        p_rvalid_d = p_gnt & (bus.p_wmask_i == 4'd0);
        d_rvalid_d = d_gnt & (bus.d_wmask_i == 4'd0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            p_rvalid_q <= p_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    // Requester-side outputs
    assign bus.p_gnt_o    = p_gnt;
    assign bus.p_stall_o  = bus.p_req_i & ~p_gnt;
    assign bus.p_rvalid_o = p_rvalid_q;
    assign bus.p_rdata_o  = bus.mem_rdata_i;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.d_rvalid_o = d_rvalid_q;
    assign bus.d_rdata_o  = bus.mem_rdata_i;

    // RAM-side mux; everything is zero when nobody is granted.
    assign bus.mem_en_o    = p_gnt | d_gnt;
    assign bus.mem_addr_o  = d_gnt ? bus.d_addr_i  : (p_gnt ? bus.p_addr_i  : 32'd0);
    assign bus.mem_wdata_o = d_gnt ? bus.d_wdata_i : (p_gnt ? bus.p_wdata_i : 32'd0);
    assign bus.mem_wmask_o = d_gnt ? bus.d_wmask_i : (p_gnt ? bus.p_wmask_i : 4'd0);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic clk_i;
    logic reset_i;
    int   total = 0;
    int   bad   = 0;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.MAX_WAIT(4), .LOCK_MAX(16)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural data RAM: 1024 words, 1-cycle synchronous read (read-before-write)
    logic [31:0] ram [0:1023];
    logic [9:0]  ram_idx;
    assign ram_idx = bus.mem_addr_o[11:2];

    always @(posedge clk_i) begin
        if (bus.mem_en_o) begin
            bus.mem_rdata_i <= ram[ram_idx];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask_o[b]) ram[ram_idx][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_p(input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        bus.p_req_i   = req;
        bus.p_addr_i  = addr;
        bus.p_wdata_i = wdata;
        bus.p_wmask_i = mask;
    endtask

    task automatic drive_d(input logic req, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input logic lock);
        bus.d_req_i   = req;
        bus.d_addr_i  = addr;
        bus.d_wdata_i = wdata;
        bus.d_wmask_i = mask;
        bus.d_lock_i  = lock;
    endtask

    task automatic set_idle;
        drive_p(1'b0, 32'd0, 32'd0, 4'd0);
        drive_d(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    // Requests asserted during reset: nothing granted, no rvalid, RAM idle.
    task automatic test_reset;
        logic [5:0] got;
        drive_p(1'b1, 32'h100, 32'h0, 4'hF);
        drive_d(1'b1, 32'h104, 32'h0, 4'h0, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        got = {bus.p_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.p_rvalid_o, bus.d_rvalid_o, |bus.mem_wmask_o};
        total++;
        if (got !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", got, 6'b0);
        end
        set_idle();
        reset_i = 1'b0;
        $display("test_reset: outputs quiet during reset");
    endtask

    // P read alone: same-cycle grant, data one cycle later.
    task automatic test_p_read;
        next_cycle();
        drive_p(1'b1, 32'h100, 32'h0, 4'h0);
        #1;
        total++;
        if ({bus.p_gnt_o, bus.p_stall_o, bus.mem_en_o, bus.mem_addr_o} !== {3'b101, 32'h100}) begin
            bad++; $display("FAIL p_read_grant got=%b/%b/%b/%h want=1/0/1/00000100",
                            bus.p_gnt_o, bus.p_stall_o, bus.mem_en_o, bus.mem_addr_o);
        end
        next_cycle();
        set_idle();
        #1;
        total++;
        if ({bus.p_rvalid_o, bus.d_rvalid_o, bus.p_rdata_o} !== {2'b10, 32'hCAFE0100}) begin
            bad++; $display("FAIL p_read_data got=%b/%b/%h want=1/0/cafe0100",
                            bus.p_rvalid_o, bus.d_rvalid_o, bus.p_rdata_o);
        end
        total++;
        if ({bus.mem_en_o, bus.mem_wmask_o} !== 5'b0) begin
            bad++; $display("FAIL idle_mem got=%b want=00000", {bus.mem_en_o, bus.mem_wmask_o});
        end
        $display("test_p_read: addr=00000100 rdata=%h", bus.p_rdata_o);
    endtask

    // Continuous P and D reads: P four times, D on the fifth, then P again.
    task automatic test_starvation;
        logic [2:0] exp_g;
        logic [1:0] exp_rv;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            drive_p(1'b1, 32'h100, 32'h0, 4'h0);
            drive_d(c < 5, 32'h104, 32'h0, 4'h0, 1'b0);
            #1;
            exp_g = {c != 4, c == 4, c == 4};
            total++;
            if ({bus.p_gnt_o, bus.d_gnt_o, bus.p_stall_o} !== exp_g) begin
                bad++; $display("FAIL starve_gnt c=%0d got=%b want=%b", c,
                                {bus.p_gnt_o, bus.d_gnt_o, bus.p_stall_o}, exp_g);
            end
            if (c > 0) begin
                exp_rv = {(c - 1) != 4, (c - 1) == 4};
                total++;
                if ({bus.p_rvalid_o, bus.d_rvalid_o} !== exp_rv) begin
                    bad++; $display("FAIL starve_rvalid c=%0d got=%b want=%b", c,
                                    {bus.p_rvalid_o, bus.d_rvalid_o}, exp_rv);
                end
            end
            if (c == 5) begin
                total++;
                if (bus.d_rdata_o !== 32'h0BAD0104) begin
                    bad++; $display("FAIL starve_d_rdata got=%h want=0bad0104", bus.d_rdata_o);
                end
            end
            $display("test_starvation: c=%0d p_gnt=%b d_gnt=%b", c, bus.p_gnt_o, bus.d_gnt_o);
        end
        next_cycle();
        set_idle();
    endtask

    // Locked D write burst with an idle reserved beat while P keeps requesting.
    task automatic test_lock_burst;
        logic exp_p, exp_d;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            drive_p(1'b1, 32'h0, 32'h0, 4'h0);
            case (c)
                0, 1, 2, 3, 4: drive_d(1'b1, 32'h200, 32'h11111111, 4'hF, 1'b1);
                5:             drive_d(1'b1, 32'h204, 32'h22222222, 4'hF, 1'b1);
                6:             drive_d(1'b0, 32'h0,   32'h0,        4'h0, 1'b1);
                7:             drive_d(1'b1, 32'h208, 32'hAAAA5555, 4'b0011, 1'b0);
                default:       drive_d(1'b0, 32'h0,   32'h0,        4'h0, 1'b0);
            endcase
            #1;
            exp_p = (c < 4) || (c == 8);
            exp_d = (c == 4) || (c == 5) || (c == 7);
            total++;
            if ({bus.p_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.p_stall_o} !== {exp_p, exp_d, exp_p | exp_d, ~exp_p}) begin
                bad++; $display("FAIL lock_burst_gnt c=%0d got=%b want=%b", c,
                                {bus.p_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.p_stall_o},
                                {exp_p, exp_d, exp_p | exp_d, ~exp_p});
            end
            total++;
            if (bus.d_rvalid_o !== 1'b0) begin
                bad++; $display("FAIL lock_burst_no_rvalid c=%0d got=%b want=0", c, bus.d_rvalid_o);
            end
            if (c == 7) begin
                total++;
                if ({bus.mem_addr_o, bus.mem_wmask_o} !== {32'h208, 4'b0011}) begin
                    bad++; $display("FAIL lock_burst_mux got=%h/%b want=00000208/0011",
                                    bus.mem_addr_o, bus.mem_wmask_o);
                end
            end
            $display("test_lock_burst: c=%0d p_gnt=%b d_gnt=%b", c, bus.p_gnt_o, bus.d_gnt_o);
        end
        next_cycle();
        set_idle();
        #1;
        total++;
        if ({ram[10'h080], ram[10'h081], ram[10'h082]} !== {32'h11111111, 32'h22222222, 32'h11225555}) begin
            bad++; $display("FAIL lock_burst_ram got=%h %h %h want=11111111 22222222 11225555",
                            ram[10'h080], ram[10'h081], ram[10'h082]);
        end
    endtask

    // D holds lock for 20 cycles: 16 locked cycles, then EXPIRED lets P in,
    // a grant in EXPIRED does not re-lock, and dropping lock returns to ARB.
    task automatic test_lock_expire;
        logic p_req, exp_p, exp_d;
        for (int c = 0; c < 22; c++) begin
            next_cycle();
            p_req = !(c == 0 || c == 19);
            drive_p(p_req, 32'h100, 32'h0, 4'h0);
            drive_d(1'b1, 32'h104, 32'h0, 4'h0, c < 20);
            #1;
            exp_d = (c <= 16) || (c == 19);
            exp_p = p_req & ~exp_d;
            total++;
            if ({bus.p_gnt_o, bus.d_gnt_o} !== {exp_p, exp_d}) begin
                bad++; $display("FAIL lock_expire_gnt c=%0d got=%b want=%b", c,
                                {bus.p_gnt_o, bus.d_gnt_o}, {exp_p, exp_d});
            end
            $display("test_lock_expire: c=%0d p_gnt=%b d_gnt=%b", c, bus.p_gnt_o, bus.d_gnt_o);
        end
        next_cycle();
        set_idle();
    endtask

    // Locked D read beat, then reset: rvalid dropped, grants off, back in ARB.
    task automatic test_reset_mid_burst;
        logic [5:0] got;
        next_cycle();
        drive_d(1'b1, 32'h104, 32'h0, 4'h0, 1'b1);
        #1;
        total++;
        if (bus.d_gnt_o !== 1'b1) begin
            bad++; $display("FAIL rst_burst_beat got=%b want=1", bus.d_gnt_o);
        end
        next_cycle();
        reset_i = 1'b1;
        drive_p(1'b1, 32'h100, 32'h12345678, 4'hF);
        #1;
        got = {bus.d_rvalid_o, bus.p_rvalid_o, bus.d_gnt_o, bus.p_gnt_o, bus.mem_en_o, |bus.mem_wmask_o};
        total++;
        if (got !== 6'b0) begin
            bad++; $display("FAIL rst_burst_outputs got=%b want=%b", got, 6'b0);
        end
        next_cycle();
        reset_i = 1'b0;
        drive_p(1'b1, 32'h100, 32'h0, 4'h0);
        drive_d(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        total++;
        if ({bus.p_gnt_o, bus.d_rvalid_o, bus.p_rvalid_o} !== 3'b100) begin
            bad++; $display("FAIL rst_burst_arb got=%b want=100",
                            {bus.p_gnt_o, bus.d_rvalid_o, bus.p_rvalid_o});
        end
        $display("test_reset_mid_burst: p_gnt after release=%b", bus.p_gnt_o);
        next_cycle();
        set_idle();
    endtask

    // P write vs D read with wait_cnt=0: P write wins, D reads the new data next cycle.
    task automatic test_collision;
        next_cycle();
        drive_p(1'b1, 32'h300, 32'hDEADBEEF, 4'b1100);
        drive_d(1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
        #1;
        total++;
        if ({bus.p_gnt_o, bus.d_gnt_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o} !==
            {2'b10, 32'h300, 32'hDEADBEEF, 4'b1100}) begin
            bad++; $display("FAIL collide_p_win got=%b%b/%h/%h/%b want=10/00000300/deadbeef/1100",
                            bus.p_gnt_o, bus.d_gnt_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o);
        end
        next_cycle();
        drive_p(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++;
        if ({bus.d_gnt_o, bus.p_rvalid_o, bus.d_rvalid_o} !== 3'b100) begin
            bad++; $display("FAIL collide_d_next got=%b want=100",
                            {bus.d_gnt_o, bus.p_rvalid_o, bus.d_rvalid_o});
        end
        next_cycle();
        set_idle();
        #1;
        total++;
        if ({bus.d_rvalid_o, bus.d_rdata_o} !== {1'b1, 32'hDEAD0304}) begin
            bad++; $display("FAIL collide_d_rdata got=%b/%h want=1/dead0304",
                            bus.d_rvalid_o, bus.d_rdata_o);
        end
        $display("test_collision: d_rdata=%h", bus.d_rdata_o);
    endtask

    initial begin
        reset_i = 1'b1;
        bus.mem_rdata_i = 32'd0;
        set_idle();
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[10'h040] = 32'hCAFE0100;   // 0x100
        ram[10'h041] = 32'h0BAD0104;   // 0x104
        ram[10'h082] = 32'h11223344;   // 0x208
        ram[10'h0C0] = 32'h01020304;   // 0x300

        test_reset();
        test_p_read();
        test_starvation();
        test_lock_burst();
        test_lock_expire();
        test_reset_mid_burst();
        test_collision();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
